sap_core: RTL and testbench

- Parametrised successor to the 8-bit single-bus teaching computer: a self-contained core with program counter, A and B registers, instruction register, flag register, RAM, microstep controller and output port.
- Data width and address width are generic.
- The output port is a valid/ready handshake that stalls the core under backpressure.
- Adds a host program-load port and a run gate, so a top level can load RAM and start, pause and observe the core.

---
 rtl/sap_pkg.sv | 28 ++
 rtl/sap_alu.sv | 27 ++
 rtl/sap_core.sv | 159 +++++++++++++++
 tb/tb_sap_core.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the sap_core: opcodes, microstep encoding, flag indices.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Bit positions inside the {CF, ZF} flag bus.
  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit. Subtract is A + ~B + 1, so the carry out
// reads as "no borrow" for SUB.
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_sum;

  // One extra bit on the adder captures the carry out of the data word.
  always_comb begin
    w_b_op = i_sub ? ~i_b : i_b;
    w_sum  = {1'b0, i_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, i_sub};
  end

  assign o_result = w_sum[DATA_W-1:0];
  assign o_carry  = w_sum[DATA_W];
  assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core.sv
// Single-bus teaching computer core: PC, MAR, A, B, IR, flags, RAM, a five-step
// microsequencer, a valid/ready output port and a host RAM load port.
module sap_core
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_halted,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_a_value,
  output logic [1:0]        o_flags
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_ram [DEPTH];

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  // Only the opcode and operand fields of the instruction are ever used,
  // so the IR keeps just those.
  logic [3:0]        r_ir_op;
  logic [ADDR_W-1:0] r_ir_opd;
  logic              r_cf;
  logic              r_zf;
  step_t             r_step;
  logic              r_out_valid;
  logic              r_halted;

  logic [DATA_W-1:0] w_ram_rd;
  logic [3:0]        w_fetch_op;
  logic              w_sta_we;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic              w_alu_zero;

  assign w_ram_rd   = r_ram[r_mar];
  assign w_fetch_op = w_ram_rd[DATA_W-1 -: 4];

  // A reset landing on T3 of STA must not leave a half-finished store behind.
  assign w_sta_we = !i_reset && !r_halted && (r_step == T3) && (r_ir_op == OP_STA);

  sap_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_sub    (r_ir_op == OP_SUB),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  // RAM write ports: core STA, then host load, so the host wins on an address clash.
  always_ff @(posedge i_clock) begin
    if (w_sta_we) begin
      r_ram[r_mar] <= r_a;
    end
    if (i_load_en) begin
      r_ram[i_load_addr] <= i_load_data;
    end
  end

  // Microstep sequencer and architectural registers; HLT freezes everything here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ir_op     <= OP_NOP;
      r_ir_opd    <= '0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b0;
      r_step      <= T0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else if (!r_halted) begin
      case (r_step)
        T0: begin
          // Pausing is only possible here, between instructions.
          if (i_run) begin
            r_mar  <= r_pc;
            r_step <= T1;
          end
        end
        T1: begin
          r_ir_op     <= w_fetch_op;
          r_ir_opd    <= w_ram_rd[ADDR_W-1:0];
          r_pc        <= r_pc + ADDR_W'(1);
          // Raise valid one step early so it is registered during T2 of OUT.
          r_out_valid <= (w_fetch_op == OP_OUT);
          r_step      <= T2;
        end
        T2: begin
          r_step <= T3;
          case (r_ir_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= r_ir_opd;
            OP_LDI: r_a <= {{(DATA_W-ADDR_W){1'b0}}, r_ir_opd};
            OP_JMP: r_pc <= r_ir_opd;
            OP_JC: begin
              if (r_cf) r_pc <= r_ir_opd;
            end
            OP_JZ: begin
              if (r_zf) r_pc <= r_ir_opd;
            end
            OP_OUT: begin
              if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
              end else begin
                r_step <= T2;
              end
            end
            OP_HLT: r_halted <= 1'b1;
            default: ;
          endcase
        end
        T3: begin
          r_step <= T4;
          case (r_ir_op)
            OP_LDA:         r_a <= w_ram_rd;
            OP_ADD, OP_SUB: r_b <= w_ram_rd;
            default: ;
          endcase
        end
        T4: begin
          r_step <= T0;
          if ((r_ir_op == OP_ADD) || (r_ir_op == OP_SUB)) begin
            r_a  <= w_alu_res;
            r_cf <= w_alu_carry;
            r_zf <= w_alu_zero;
          end
        end
        default: r_step <= T0;
      endcase
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_data       = r_out_valid ? r_a : '0;
  assign o_halted         = r_halted;
  assign o_pc             = r_pc;
  assign o_a_value        = r_a;
  assign o_flags[FLAG_CF] = r_cf;
  assign o_flags[FLAG_ZF] = r_zf;

endmodule

// File: tb/tb_sap_core.sv
// Bench for sap_core: hand-computed program table, instruction-level reference
// model driven by random programs, and hand sequences for stall/reset/wide-word cases.
module tb_sap_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit / 4-bit address instance
  logic       reset, run, load_en, out_ready;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] out_data, a_value;
  logic       out_valid, halted;
  logic [3:0] pc;
  logic [1:0] flags;

  // 16-bit / 8-bit address instance
  logic        x_reset, x_run, x_load_en, x_out_ready;
  logic [7:0]  x_load_addr;
  logic [15:0] x_load_data;
  logic [15:0] x_out_data, x_a_value;
  logic        x_out_valid, x_halted;
  logic [7:0]  x_pc;
  logic [1:0]  x_flags;

  sap_core #(.DATA_W(8), .ADDR_W(4)) u_dut (
    .i_clock(clk), .i_reset(reset), .i_run(run),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_halted(halted), .o_pc(pc), .o_a_value(a_value), .o_flags(flags)
  );

  sap_core #(.DATA_W(16), .ADDR_W(8)) u_w (
    .i_clock(clk), .i_reset(x_reset), .i_run(x_run),
    .i_load_en(x_load_en), .i_load_addr(x_load_addr), .i_load_data(x_load_data),
    .o_out_data(x_out_data), .o_out_valid(x_out_valid), .i_out_ready(x_out_ready),
    .o_halted(x_halted), .o_pc(x_pc), .o_a_value(x_a_value), .o_flags(x_flags)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output port monitor: collects accepted words and checks idle/halt rules.
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (!out_valid) chk("out_data_idle_zero", 32'(out_data), 32'h0);
    if (halted || reset) chk("no_valid_halt_or_reset", 32'(out_valid), 32'h0);
  end

  // Instruction-level reference model
  logic [0:15][7:0] cur_prog;
  logic [7:0] m_ram [16];
  logic [7:0] m_a;
  logic       m_cf, m_zf, m_halt;
  logic [3:0] m_pc;
  logic [7:0] exp_q[$];

  task automatic model_run(input int k);
    int         sum;
    logic [7:0] ir, b;
    logic [3:0] opd;
    for (int i = 0; i < 16; i++) m_ram[i] = cur_prog[i];
    m_a = 0; m_cf = 0; m_zf = 0; m_halt = 0; m_pc = 0;
    exp_q.delete();
    for (int i = 0; i < k && !m_halt; i++) begin
      ir   = m_ram[m_pc];
      m_pc = m_pc + 4'd1;
      opd  = ir[3:0];
      case (ir[7:4])
        4'h1: m_a = m_ram[opd];
        4'h2: begin
          sum  = int'(m_a) + int'(m_ram[opd]);
          m_cf = (sum > 255);
          m_a  = 8'(sum);
          m_zf = (m_a == 8'd0);
        end
        4'h3: begin
          b    = m_ram[opd];
          m_cf = (m_a >= b);
          m_a  = m_a - b;
          m_zf = (m_a == 8'd0);
        end
        4'h4: m_ram[opd] = m_a;
        4'h5: m_a = {4'h0, opd};
        4'h6: m_pc = opd;
        4'h7: if (m_cf) m_pc = opd;
        4'h8: if (m_zf) m_pc = opd;
        4'hE: exp_q.push_back(m_a);
        4'hF: m_halt = 1;
        default: ;
      endcase
    end
  endtask

  // Reset the core, load all 16 words through the host port, leave it released.
  task automatic load_prog();
    reset = 1; run = 0; load_en = 0; out_ready = 1;
    tick();
    for (int a = 0; a < 16; a++) begin
      load_en = 1; load_addr = 4'(a); load_data = cur_prog[a];
      tick();
    end
    load_en = 0;
    reset = 0;
    got_q.delete();
  endtask

  task automatic run_instr(input int k);
    run = 1;
    repeat (5 * k) tick();
    run = 0;
  endtask

  typedef struct {
    string            name;
    logic [0:15][7:0] prog;
    int               k;
    logic [7:0]       e_a;
    logic [1:0]       e_flags;
    logic [3:0]       e_pc;
    logic             e_halt;
    int               e_nout;
    logic [7:0]       e_out0;
    logic [3:0]       e_addr;
    logic [7:0]       e_mem;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [3:0] op;
    int         s, n;
    logic [7:0]  w_addr [7];
    logic [15:0] w_data [7];

    reset = 1; run = 0; load_en = 0; load_addr = 0; load_data = 0; out_ready = 1;
    x_reset = 1; x_run = 0; x_load_en = 0; x_load_addr = 0; x_load_data = 0; x_out_ready = 1;

    tbl[0] = '{"add_out", {8'h1E,8'h2F,8'hE0,8'hF0, 8'h00,8'h00,8'h00,8'h00,
                           8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'd28,8'd14},
               6, 8'd42, 2'b00, 4'd4, 1'b1, 1, 8'd42, 4'd14, 8'd28};
    tbl[1] = '{"sub_zero_jz", {8'h55,8'h3F,8'h87,8'hF0, 8'h00,8'h00,8'h00,8'hE0,
                               8'hF0,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h05},
               3, 8'd0, 2'b11, 4'd7, 1'b0, 0, 8'd0, 4'd15, 8'd5};
    tbl[2] = '{"jz_taken_out", {8'h55,8'h3F,8'h87,8'hF0, 8'h00,8'h00,8'h00,8'hE0,
                                8'hF0,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h05},
               5, 8'd0, 2'b11, 4'd9, 1'b1, 1, 8'd0, 4'd15, 8'd5};
    tbl[3] = '{"jz_not_taken", {8'h55,8'h3F,8'h87,8'hF0, 8'h00,8'h00,8'h00,8'hE0,
                                8'hF0,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h03},
               5, 8'd2, 2'b10, 4'd4, 1'b1, 0, 8'd0, 4'd15, 8'd3};
    tbl[4] = '{"sta_lda_wrap", {8'h59,8'h4F,8'h50,8'h1F, 8'h00,8'h00,8'h00,8'h00,
                                8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00},
               16, 8'd9, 2'b00, 4'd0, 1'b0, 0, 8'd0, 4'd15, 8'd9};
    tbl[5] = '{"add_carry_jc", {8'h1E,8'h2F,8'h76,8'hF0, 8'h00,8'h00,8'hE0,8'hF0,
                                8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'd200,8'd100},
               6, 8'd44, 2'b10, 4'd8, 1'b1, 1, 8'd44, 4'd14, 8'd200};
    tbl[6] = '{"jmp_unlisted", {8'h9A,8'h64,8'h00,8'h00, 8'h5C,8'hE0,8'hF0,8'h00,
                                8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00},
               6, 8'd12, 2'b00, 4'd7, 1'b1, 1, 8'd12, 4'd4, 8'h5C};
    tbl[7] = '{"sub_borrow", {8'h53,8'h3F,8'h76,8'hF0, 8'h00,8'h00,8'hE0,8'hF0,
                              8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h05},
               5, 8'hFE, 2'b00, 4'd4, 1'b1, 0, 8'd0, 4'd15, 8'd5};

    // Reset state
    repeat (2) tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_a", 32'(a_value), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);

    // Hand-computed program table
    for (int t = 0; t < 8; t++) begin
      cur_prog = tbl[t].prog;
      load_prog();
      run_instr(tbl[t].k);
      chk({tbl[t].name, "_pc"}, 32'(pc), 32'(tbl[t].e_pc));
      chk({tbl[t].name, "_a"}, 32'(a_value), 32'(tbl[t].e_a));
      chk({tbl[t].name, "_flags"}, 32'(flags), 32'(tbl[t].e_flags));
      chk({tbl[t].name, "_halted"}, 32'(halted), 32'(tbl[t].e_halt));
      chk({tbl[t].name, "_nout"}, 32'(got_q.size()), 32'(tbl[t].e_nout));
      if (tbl[t].e_nout > 0 && got_q.size() > 0)
        chk({tbl[t].name, "_out0"}, 32'(got_q[0]), 32'(tbl[t].e_out0));
      chk({tbl[t].name, "_mem"}, 32'(u_dut.r_ram[tbl[t].e_addr]), 32'(tbl[t].e_mem));
    end

    // Random programs against the reference model
    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 3) == 0) begin
          cur_prog[a] = 8'($urandom);
        end else begin
          s  = int'($urandom_range(0, 11));
          op = (s < 9) ? 4'(s) : (s == 9) ? 4'hE : (s == 10) ? 4'hF : 4'hB;
          cur_prog[a] = {op, 4'($urandom)};
        end
      end
      model_run(12);
      load_prog();
      run_instr(12);
      chk($sformatf("rnd%0d_pc", r), 32'(pc), 32'(m_pc));
      chk($sformatf("rnd%0d_a", r), 32'(a_value), 32'(m_a));
      chk($sformatf("rnd%0d_flags", r), 32'(flags), 32'({m_cf, m_zf}));
      chk($sformatf("rnd%0d_halted", r), 32'(halted), 32'(m_halt));
      chk($sformatf("rnd%0d_nout", r), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk($sformatf("rnd%0d_out%0d", r, i), 32'(got_q[i]), 32'(exp_q[i]));
      for (int a = 0; a < 16; a++)
        chk($sformatf("rnd%0d_ram%0d", r, a), 32'(u_dut.r_ram[a]), 32'(m_ram[a]));
    end

    // Output backpressure: LDI 7, OUT, HLT with ready low for 10 cycles
    cur_prog = {8'h57,8'hE0,8'hF0,8'h00, 8'h00,8'h00,8'h00,8'h00,
                8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00};
    load_prog();
    out_ready = 0;
    run = 1;
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    chk("bp_valid_seen", 32'(out_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("bp_hold%0d_data", i), 32'(out_data), 32'h7);
      chk($sformatf("bp_hold%0d_pc", i), 32'(pc), 32'h2);
      tick();
    end
    out_ready = 1;
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'h0);
    chk("bp_nout", 32'(got_q.size()), 32'h1);
    if (got_q.size() > 0) chk("bp_out0", 32'(got_q[0]), 32'h7);
    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    chk("bp_halted", 32'(halted), 32'h1);
    run = 0;

    // Reset during T3 of STA: store abandoned, program re-runs afterwards
    cur_prog = {8'h59,8'h4F,8'hF0,8'h00, 8'h00,8'h00,8'h00,8'h00,
                8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h33};
    load_prog();
    run = 1;
    repeat (8) tick();
    chk("mid_sta_step_t3", 32'(u_dut.r_step), 32'h3);
    reset = 1;
    tick();
    chk("mid_rst_ram15", 32'(u_dut.r_ram[15]), 32'h33);
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_a", 32'(a_value), 32'h0);
    chk("mid_rst_flags", 32'(flags), 32'h0);
    chk("mid_rst_step", 32'(u_dut.r_step), 32'h0);
    chk("mid_rst_ram0", 32'(u_dut.r_ram[0]), 32'h59);
    reset = 0;
    repeat (15) tick();
    chk("rerun_halted", 32'(halted), 32'h1);
    chk("rerun_a", 32'(a_value), 32'h9);
    chk("rerun_ram15", 32'(u_dut.r_ram[15]), 32'h9);
    chk("rerun_pc", 32'(pc), 32'h3);
    run = 0;

    // Wide core: 0x7FFF + 0x8001, then host load colliding with STA 0x12
    w_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12};
    w_data = '{16'h1010, 16'h2011, 16'h4012, 16'hF000, 16'h7FFF, 16'h8001, 16'h0000};
    tick();
    for (int i = 0; i < 7; i++) begin
      x_load_en = 1; x_load_addr = w_addr[i]; x_load_data = w_data[i];
      tick();
    end
    x_load_en = 0;
    x_reset = 0;
    x_run = 1;
    repeat (10) tick();
    chk("w_add_a", 32'(x_a_value), 32'h0);
    chk("w_add_flags", 32'(x_flags), 32'h3);
    repeat (3) tick();
    x_load_en = 1; x_load_addr = 8'h12; x_load_data = 16'hBEEF;
    tick();
    x_load_en = 0;
    repeat (10) tick();
    chk("w_collide_ram", 32'(u_w.r_ram[8'h12]), 32'hBEEF);
    chk("w_halted", 32'(x_halted), 32'h1);
    chk("w_pc", 32'(x_pc), 32'h4);
    chk("w_a_final", 32'(x_a_value), 32'h0);
    x_run = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
